// File: rtl/cic_pkg.sv
// Shared helpers for the CIC integrator chain: width math and parameter limits.
package cic_pkg;

  localparam int MAX_STAGES   = 8;
  localparam int MAX_CHANNELS = 16;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // A single channel still needs one tag bit so the port never collapses to zero width.
  function automatic int ch_width(input int num_channels);
    return (num_channels > 1) ? clog2(num_channels) : 1;
  endfunction

  // Hogenauer bit growth: accumulator width needed for a lossless CIC of rate r, delay m.
  function automatic int acc_width_req(input int input_width, input int n_stages,
                                       input int rate, input int diff_delay);
    return input_width + n_stages * clog2(rate * diff_delay);
  endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One integrator stage with per-channel accumulators; valid and tag ride alongside the sum.
module cic_integrator_stage
  import cic_pkg::*;
#(
  parameter int ACC_WIDTH    = 32,
  parameter int NUM_CHANNELS = 2,
  localparam int CH_WIDTH    = ch_width(NUM_CHANNELS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 up_valid,
  input  logic [CH_WIDTH-1:0]  up_tag,
  input  logic [ACC_WIDTH-1:0] up_data,
  output logic                 valid,
  output logic [CH_WIDTH-1:0]  tag,
  output logic [ACC_WIDTH-1:0] sum
);

  logic [ACC_WIDTH-1:0] acc [NUM_CHANNELS];
  logic [ACC_WIDTH-1:0] acc_next;

  // Modulo-2^ACC_WIDTH wrap is intentional; the comb section cancels it.
  assign acc_next = acc[up_tag] + up_data;

  // Update only the tagged channel's accumulator; idle cycles hold everything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) acc[c] <= '0;
      valid <= 1'b0;
      tag   <= '0;
      sum   <= '0;
    end else begin
      valid <= up_valid;
      if (up_valid) begin
        acc[up_tag] <= acc_next;
        tag         <= up_tag;
        sum         <= acc_next;
      end
    end
  end

endmodule

// File: rtl/cic_integrator_chain.sv
// Multi-stage, multi-channel CIC integrator section with channel tagging and MSB output slice.
// Optional macro CIC_INTEG_ROUND_EN: round the output slice half-up instead of truncating.
module cic_integrator_chain
  import cic_pkg::*;
#(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int N_STAGES     = 4,
  parameter int NUM_CHANNELS = 2,
  // Optional bit-growth check: set DECIM_RATE > 0 to require a lossless ACC_WIDTH.
  parameter int DECIM_RATE   = 0,
  parameter int DIFF_DELAY   = 1,
  localparam int CH_WIDTH    = ch_width(NUM_CHANNELS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    strobe_in,
  input  logic                    sync_in,
  input  logic [INPUT_WIDTH-1:0]  d_in,
  output logic                    strobe_out,
  output logic [CH_WIDTH-1:0]     ch_out,
  output logic [OUTPUT_WIDTH-1:0] d_out
);

  if (OUTPUT_WIDTH > ACC_WIDTH || ACC_WIDTH < INPUT_WIDTH ||
      N_STAGES < 1 || N_STAGES > MAX_STAGES ||
      NUM_CHANNELS < 1 || NUM_CHANNELS > MAX_CHANNELS) begin : g_bad_param
    $error("cic_integrator_chain: illegal width or count parameters");
  end

  if (DECIM_RATE > 0 &&
      ACC_WIDTH < acc_width_req(INPUT_WIDTH, N_STAGES, DECIM_RATE, DIFF_DELAY)) begin : g_bad_growth
    $error("cic_integrator_chain: ACC_WIDTH too small for CIC bit growth");
  end

  localparam logic [CH_WIDTH-1:0] LAST_CH   = CH_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [CH_WIDTH-1:0] SYNC_NEXT = (NUM_CHANNELS > 1) ? CH_WIDTH'(1) : '0;

  logic [CH_WIDTH-1:0]  ch_cnt;
  logic                 stage_valid [N_STAGES+1];
  logic [CH_WIDTH-1:0]  stage_tag   [N_STAGES+1];
  logic [ACC_WIDTH-1:0] stage_data  [N_STAGES+1];
  logic [ACC_WIDTH-1:0] rounded;
  logic [OUTPUT_WIDTH-1:0] d_next;

  // Stage 1 integrates on the sampling edge itself, so the input feeds it directly.
  assign stage_valid[0] = strobe_in;
  assign stage_tag[0]   = sync_in ? '0 : ch_cnt;
  assign stage_data[0]  = ACC_WIDTH'($signed(d_in));

  // Input channel counter: sync forces this sample to channel 0, else round-robin.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ch_cnt <= '0;
    end else if (strobe_in) begin
      if (sync_in)                ch_cnt <= SYNC_NEXT;
      else if (ch_cnt == LAST_CH) ch_cnt <= '0;
      else                        ch_cnt <= ch_cnt + CH_WIDTH'(1);
    end
  end

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    cic_integrator_stage #(
      .ACC_WIDTH   (ACC_WIDTH),
      .NUM_CHANNELS(NUM_CHANNELS)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .up_valid(stage_valid[k]),
      .up_tag  (stage_tag[k]),
      .up_data (stage_data[k]),
      .valid   (stage_valid[k+1]),
      .tag     (stage_tag[k+1]),
      .sum     (stage_data[k+1])
    );
  end

`ifdef CIC_INTEG_ROUND_EN
  if (OUTPUT_WIDTH < ACC_WIDTH) begin : g_round
    // Half-up: add half an output LSB; overflow past the top wraps like the integrators.
    assign rounded = stage_data[N_STAGES] + (ACC_WIDTH'(1) << (ACC_WIDTH - OUTPUT_WIDTH - 1));
  end else begin : g_no_round
    assign rounded = stage_data[N_STAGES];
  end
`else
  assign rounded = stage_data[N_STAGES];
`endif

  assign d_next = OUTPUT_WIDTH'(rounded >> (ACC_WIDTH - OUTPUT_WIDTH));

  // Output register: capture the MSB slice when the last stage produced a sample.
  always_ff @(posedge clock) begin
    if (!reset) begin
      strobe_out <= 1'b0;
      ch_out     <= '0;
      d_out      <= '0;
    end else begin
      strobe_out <= stage_valid[N_STAGES];
      if (stage_valid[N_STAGES]) begin
        ch_out <= stage_tag[N_STAGES];
        d_out  <= d_next;
      end
    end
  end

endmodule

// File: tb/tb_cic_integrator_chain.sv
// Self-checking bench: four parameterisations of the chain driven by one stimulus stream,
// with a behavioural per-channel model feeding an expected-output scoreboard.
module tb_cic_integrator_chain;

  localparam int NDUT = 4;
  localparam int PN [NDUT] = '{4, 1, 1, 2};
  localparam int PC [NDUT] = '{1, 2, 1, 3};
  localparam int PA [NDUT] = '{32, 32, 16, 16};
  localparam int PO [NDUT] = '{32, 32, 16, 8};

  logic clock = 1'b0;
  logic reset;
  logic strobe_in;
  logic sync_in;
  logic [15:0] d_in;

  always #5 clock = ~clock;

  logic so0, so1, so2, so3;
  logic [0:0] ch0, ch1, ch2;
  logic [1:0] ch3;
  logic [31:0] do0, do1;
  logic [15:0] do2;
  logic [7:0]  do3;

  cic_integrator_chain #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(32), .ACC_WIDTH(32),
                         .N_STAGES(4), .NUM_CHANNELS(1)) u_dut0 (
    .clock(clock), .reset(reset), .strobe_in(strobe_in), .sync_in(sync_in), .d_in(d_in),
    .strobe_out(so0), .ch_out(ch0), .d_out(do0));

  cic_integrator_chain #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(32), .ACC_WIDTH(32),
                         .N_STAGES(1), .NUM_CHANNELS(2)) u_dut1 (
    .clock(clock), .reset(reset), .strobe_in(strobe_in), .sync_in(sync_in), .d_in(d_in),
    .strobe_out(so1), .ch_out(ch1), .d_out(do1));

  cic_integrator_chain #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(16), .ACC_WIDTH(16),
                         .N_STAGES(1), .NUM_CHANNELS(1)) u_dut2 (
    .clock(clock), .reset(reset), .strobe_in(strobe_in), .sync_in(sync_in), .d_in(d_in),
    .strobe_out(so2), .ch_out(ch2), .d_out(do2));

  cic_integrator_chain #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(8), .ACC_WIDTH(16),
                         .N_STAGES(2), .NUM_CHANNELS(3)) u_dut3 (
    .clock(clock), .reset(reset), .strobe_in(strobe_in), .sync_in(sync_in), .d_in(d_in),
    .strobe_out(so3), .ch_out(ch3), .d_out(do3));

  logic        obs_so [NDUT];
  logic [3:0]  obs_ch [NDUT];
  logic [31:0] obs_d  [NDUT];

  always_comb begin
    obs_so[0] = so0;          obs_so[1] = so1;          obs_so[2] = so2;          obs_so[3] = so3;
    obs_ch[0] = {3'd0, ch0};  obs_ch[1] = {3'd0, ch1};  obs_ch[2] = {3'd0, ch2};  obs_ch[3] = {2'd0, ch3};
    obs_d[0]  = do0;          obs_d[1]  = do1;          obs_d[2]  = {16'd0, do2}; obs_d[3]  = {24'd0, do3};
  end

  typedef struct {
    int          dut;
    int          due;
    logic [3:0]  ch;
    logic [31:0] d;
  } exp_t;

  exp_t        sb [$];
  longint      acc_m [NDUT][8][16];
  int          ch_m [NDUT];
  logic [3:0]  last_ch [NDUT];
  logic [31:0] last_d [NDUT];
  int          edge_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      for (int k = 0; k < 8; k++)
        for (int c = 0; c < 16; c++) acc_m[i][k][c] = 0;
      ch_m[i]    = 0;
      last_ch[i] = '0;
      last_d[i]  = '0;
    end
    sb.delete();
  endtask

  task automatic model_sample(input logic [15:0] d, input logic syn);
    for (int i = 0; i < NDUT; i++) begin
      int     tag;
      longint mask;
      longint x;
      exp_t   e;
      if (syn) begin
        tag     = 0;
        ch_m[i] = (PC[i] > 1) ? 1 : 0;
      end else begin
        tag     = ch_m[i];
        ch_m[i] = (ch_m[i] + 1) % PC[i];
      end
      mask = (longint'(1) << PA[i]) - 1;
      x    = longint'($signed(d)) & mask;
      for (int k = 0; k < PN[i]; k++) begin
        acc_m[i][k][tag] = (acc_m[i][k][tag] + x) & mask;
        x = acc_m[i][k][tag];
      end
`ifdef CIC_INTEG_ROUND_EN
      if (PO[i] < PA[i]) x = (x + (longint'(1) << (PA[i] - PO[i] - 1))) & mask;
`endif
      e.dut = i;
      e.due = edge_cnt + PN[i];
      e.ch  = 4'(tag);
      e.d   = 32'(x >> (PA[i] - PO[i]));
      sb.push_back(e);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NDUT; i++) begin
      logic exp_so;
      exp_so = 1'b0;
      for (int j = 0; j < sb.size(); j++) begin
        if (sb[j].dut == i && sb[j].due == edge_cnt) begin
          exp_so     = 1'b1;
          last_ch[i] = sb[j].ch;
          last_d[i]  = sb[j].d;
          sb.delete(j);
          break;
        end
      end
      n_tests++;
      assert (obs_so[i] === exp_so) else begin
        n_fail++;
        $error("FAIL strobe_out dut%0d edge %0d: observed %0b expected %0b", i, edge_cnt, obs_so[i], exp_so);
      end
      n_tests++;
      assert (obs_d[i] === last_d[i]) else begin
        n_fail++;
        $error("FAIL d_out dut%0d edge %0d: observed %h expected %h", i, edge_cnt, obs_d[i], last_d[i]);
      end
      n_tests++;
      assert (obs_ch[i] === last_ch[i]) else begin
        n_fail++;
        $error("FAIL ch_out dut%0d edge %0d: observed %0d expected %0d", i, edge_cnt, obs_ch[i], last_ch[i]);
      end
    end
  endtask

  task automatic step(input logic rst_v, input logic stb, input logic syn, input logic [15:0] d);
    reset     = rst_v;
    strobe_in = stb;
    sync_in   = syn;
    d_in      = d;
    @(posedge clock);
    edge_cnt++;
    if (!rst_v)   model_reset();
    else if (stb) model_sample(d, syn);
    @(negedge clock);
    check_all();
  endtask

  initial begin
    model_reset();

    // reset held with live strobes, then released idle
    step(1'b0, 1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 16'h1234);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);

    // impulse
    step(1'b1, 1'b1, 1'b1, 16'h0001);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);

    // positive full-scale repeated to force a wrap
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'h7FFF);
    step(1'b1, 1'b1, 1'b0, 16'h7FFF);
    step(1'b1, 1'b1, 1'b0, 16'h7FFF);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);

    // interleaved +1/-1, a strobe gap, then continuation
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'h0001);
    step(1'b1, 1'b1, 1'b0, 16'hFFFF);
    step(1'b1, 1'b1, 1'b0, 16'h0001);
    step(1'b1, 1'b1, 1'b0, 16'hFFFF);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0001);
    step(1'b1, 1'b1, 1'b0, 16'hFFFF);

    // sync re-asserted on the sample after a channel-0 sample
    step(1'b1, 1'b1, 1'b1, 16'h0003);
    step(1'b1, 1'b1, 1'b1, 16'h0004);
    step(1'b1, 1'b1, 1'b0, 16'h0007);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);

    // reset in the middle of back-to-back strobes
    step(1'b1, 1'b1, 1'b0, 16'h0100);
    step(1'b1, 1'b1, 1'b0, 16'h0200);
    step(1'b0, 1'b1, 1'b0, 16'h0300);
    step(1'b1, 1'b1, 1'b1, 16'h0005);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);

    // rounding boundary on the narrow-output instance
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'h0180);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);

    // random traffic with gaps, occasional sync and rare resets
    for (int i = 0; i < 400; i++) begin
      logic stb, syn, rst_v;
      stb   = ($urandom_range(0, 3) != 0);
      syn   = stb && ($urandom_range(0, 7) == 0);
      rst_v = ($urandom_range(0, 149) != 0);
      step(rst_v, stb, syn, 16'($urandom));
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);

    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL pending_outputs: observed %0d undelivered expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
